// File: rtl/bm_key_solver.sv
// bm_key_solver
//   Key-equation stage of the DVB-T RS(204,188) decoder (t=8). Runs the
//   inversionless Berlekamp-Massey algorithm over 16 syndromes, one
//   iteration per clock. It then inverts Lambda0 serially and normalises the
//   locator so that Sigma0 = 1 is implied.
//
//   Ports
//     Clk        in   rising-edge clock
//     Reset      in   synchronous, active-low reset
//     Start      in   one-cycle request, sampled only in IDLE
//     Syndromes  in   S1 in [7:0] ... S16 in [127:120], latched on accept
//     Busy       out  a block is in progress
//     Done       out  one-cycle pulse, results valid from this cycle
//     Sigma1..8  out  normalised locator coefficients, held until next Done
//     Num_Errors out  final LFSR length L
//     Fail       out  uncorrectable (L>8 or deg(Lambda)!=L)
//     State_Dbg  out  current FSM state, for observation only
//
//   Handshake: Start is a request pulse that is accepted only on an edge
//   where the FSM is IDLE. Requests in any other state are dropped. Each
//   accepted request produces exactly one Done pulse unless Reset intervenes.
//   Done is asserted while the FSM is already back in IDLE, so a Start held
//   during the Done cycle is accepted.
//
//   Build option BM_ZERO_BYPASS_EN: when it is defined, an all-zero syndrome
//   set jumps straight from IDLE to NORM. Done then arrives two edges after
//   Start, with the same output values as the full path.
module bm_key_solver #(
   parameter int          M         = 8,
   parameter logic [8:0]  PRIM_POLY = 9'h11D
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [16*M-1:0]  Syndromes,
   output logic             Busy,
   output logic             Done,
   output logic [M-1:0]     Sigma1,
   output logic [M-1:0]     Sigma2,
   output logic [M-1:0]     Sigma3,
   output logic [M-1:0]     Sigma4,
   output logic [M-1:0]     Sigma5,
   output logic [M-1:0]     Sigma6,
   output logic [M-1:0]     Sigma7,
   output logic [M-1:0]     Sigma8,
   output logic [4:0]       Num_Errors,
   output logic             Fail,
   output logic [2:0]       State_Dbg
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CALC = 3'd1,
      INV  = 3'd2,
      NORM = 3'd3,
      DONE = 3'd4
   } state_e;

   // GF(2^8) multiply: shift-and-add with modular reduction at each shift.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] p;
      logic [M-1:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) p = p ^ aa;
         if (aa[M-1]) aa = {aa[M-2:0], 1'b0} ^ PRIM_POLY[M-1:0];
         else         aa = {aa[M-2:0], 1'b0};
      end
      return p;
   endfunction

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;          // iteration index r in CALC, step in INV
   logic [M-1:0]  lambda_q [0:8];
   logic [M-1:0]  lambda_d [0:8];
   logic [M-1:0]  b_q [0:8];
   logic [M-1:0]  b_d [0:8];
   logic [M-1:0]  gamma_q, gamma_d;
   logic [4:0]    l_q, l_d;
   logic [M-1:0]  inv_q, inv_d;
   // syn_q[0] is S_{r+1}; hist_q[j] is S_{r+1-j} (zero before S1 exists).
   logic [M-1:0]  syn_q [0:15];
   logic [M-1:0]  syn_d [0:15];
   logic [M-1:0]  hist_q [1:8];
   logic [M-1:0]  hist_d [1:8];
   logic [M-1:0]  sigma_q [1:8];
   logic [M-1:0]  sigma_d [1:8];
   logic [4:0]    num_q, num_d;
   logic          fail_q, fail_d;
   logic          done_q, done_d;

   // BM iteration datapath
   logic [M-1:0]  win [0:8];
   logic [M-1:0]  delta;
   logic          upd;
   logic [M-1:0]  lam_upd [0:8];
   logic [3:0]    deg;
   logic [M-1:0]  inv_base, inv_sq, inv_next;

`ifdef BM_ZERO_BYPASS_EN
   logic          syn_zero;
   assign syn_zero = (Syndromes == '0);
`endif

   always_comb begin
      win[0] = syn_q[0];
      for (int j = 1; j <= 8; j++) win[j] = hist_q[j];

      delta = '0;
      for (int j = 0; j <= 8; j++) delta = delta ^ gf_mul(lambda_q[j], win[j]);

      // Length change only when the discrepancy is nonzero and 2L <= r.
      upd = (delta != '0) && ({l_q, 1'b0} <= {2'b00, cnt_q});

      // Lambda' = gamma*Lambda ^ delta*(x*B); the x^9 term falls off.
      lam_upd[0] = gf_mul(gamma_q, lambda_q[0]);
      for (int j = 1; j <= 8; j++)
         lam_upd[j] = gf_mul(gamma_q, lambda_q[j]) ^ gf_mul(delta, b_q[j-1]);

      deg = '0;
      for (int j = 1; j <= 8; j++)
         if (lambda_q[j] != '0) deg = j[3:0];

      // Lambda0^254 by left-to-right square-and-multiply over 254 = 8'b1111_1110.
      // Step 0 starts from Lambda0 itself (the leading 1 bit). Steps 0..5
      // square and multiply; step 6 only squares.
      inv_base = (cnt_q == 4'd0) ? lambda_q[0] : inv_q;
      inv_sq   = gf_mul(inv_base, inv_base);
      inv_next = (cnt_q == 4'd6) ? inv_sq : gf_mul(inv_sq, lambda_q[0]);
   end

   // Next-state / register update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lambda_d = lambda_q;
      b_d      = b_q;
      gamma_d  = gamma_q;
      l_d      = l_q;
      inv_d    = inv_q;
      syn_d    = syn_q;
      hist_d   = hist_q;
      sigma_d  = sigma_q;
      num_d    = num_q;
      fail_d   = fail_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               for (int i = 0; i < 16; i++) syn_d[i] = Syndromes[M*i +: M];
               for (int j = 1; j <= 8; j++) hist_d[j] = '0;
               for (int j = 0; j <= 8; j++) begin
                  lambda_d[j] = (j == 0) ? M'(1) : '0;
                  b_d[j]      = (j == 0) ? M'(1) : '0;
               end
               gamma_d = M'(1);
               l_d     = '0;
               cnt_d   = '0;
               inv_d   = M'(1);
               state_d = CALC;
`ifdef BM_ZERO_BYPASS_EN
               if (syn_zero) state_d = NORM;
`endif
            end
         end

         CALC: begin
            lambda_d = lam_upd;
            if (upd) begin
               b_d     = lambda_q;
               l_d     = {1'b0, cnt_q} + 5'd1 - l_q;
               gamma_d = delta;
            end else begin
               b_d[0] = '0;
               for (int j = 1; j <= 8; j++) b_d[j] = b_q[j-1];
            end
            for (int i = 0; i < 15; i++) syn_d[i] = syn_q[i+1];
            syn_d[15] = '0;
            hist_d[1] = syn_q[0];
            for (int j = 2; j <= 8; j++) hist_d[j] = hist_q[j-1];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               cnt_d   = '0;
               state_d = INV;
            end
         end

         INV: begin
            inv_d = inv_next;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd6) begin
               cnt_d   = '0;
               state_d = NORM;
            end
         end

         NORM: begin
            for (int j = 0; j <= 8; j++) lambda_d[j] = gf_mul(lambda_q[j], inv_q);
            state_d = DONE;
         end

         DONE: begin
            // Scaling by a nonzero inverse keeps the degree, so the degree
            // is taken from the normalised Lambda here.
            for (int j = 1; j <= 8; j++) sigma_d[j] = lambda_q[j];
            num_d   = l_q;
            fail_d  = (l_q > 5'd8) || ({1'b0, deg} != l_q);
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gamma_q <= '0;
         l_q     <= '0;
         inv_q   <= '0;
         num_q   <= '0;
         fail_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int j = 0; j <= 8; j++) begin
            lambda_q[j] <= '0;
            b_q[j]      <= '0;
         end
         for (int i = 0; i < 16; i++) syn_q[i] <= '0;
         for (int j = 1; j <= 8; j++) begin
            hist_q[j]  <= '0;
            sigma_q[j] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gamma_q  <= gamma_d;
         l_q      <= l_d;
         inv_q    <= inv_d;
         num_q    <= num_d;
         fail_q   <= fail_d;
         done_q   <= done_d;
         lambda_q <= lambda_d;
         b_q      <= b_d;
         syn_q    <= syn_d;
         hist_q   <= hist_d;
         sigma_q  <= sigma_d;
      end
   end

   assign Busy       = (state_q != IDLE);
   assign Done       = done_q;
   assign Sigma1     = sigma_q[1];
   assign Sigma2     = sigma_q[2];
   assign Sigma3     = sigma_q[3];
   assign Sigma4     = sigma_q[4];
   assign Sigma5     = sigma_q[5];
   assign Sigma6     = sigma_q[6];
   assign Sigma7     = sigma_q[7];
   assign Sigma8     = sigma_q[8];
   assign Num_Errors = num_q;
   assign Fail       = fail_q;
   assign State_Dbg  = state_q;

endmodule

// File: tb/tb_bm_key_solver.sv
// Testbench for bm_key_solver. It uses directed syndrome vectors. Single-error
// and degenerate cases use hand-computed constants. Multi-error cases derive
// syndromes and the expected locator from the chosen error positions: the
// locator is the product of (1 + X_i x). Expected results go through exp_q.
module tb_bm_key_solver;

   logic          Clk;
   logic          Reset;
   logic          Start;
   logic [127:0]  Syndromes;
   logic          Busy;
   logic          Done;
   logic [7:0]    Sigma1, Sigma2, Sigma3, Sigma4, Sigma5, Sigma6, Sigma7, Sigma8;
   logic [4:0]    Num_Errors;
   logic          Fail;
   logic [2:0]    State_Dbg;

   int n_checks = 0;
   int n_fail   = 0;

   // {sigma8..sigma1, num_errors, fail}
   logic [69:0] exp_q[$];

`ifdef BM_ZERO_BYPASS_EN
   localparam int ZERO_LAT = 2;
`else
   localparam int ZERO_LAT = 25;
`endif

   bm_key_solver dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Start      (Start),
      .Syndromes  (Syndromes),
      .Busy       (Busy),
      .Done       (Done),
      .Sigma1     (Sigma1),
      .Sigma2     (Sigma2),
      .Sigma3     (Sigma3),
      .Sigma4     (Sigma4),
      .Sigma5     (Sigma5),
      .Sigma6     (Sigma6),
      .Sigma7     (Sigma7),
      .Sigma8     (Sigma8),
      .Num_Errors (Num_Errors),
      .Fail       (Fail),
      .State_Dbg  (State_Dbg)
   );

   // ---------------- clock / reset ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference field arithmetic ----------------
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] ref_pow(input logic [7:0] x, input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < e; i++) r = ref_mul(r, x);
      return r;
   endfunction

   // Unit errors at alpha^locs[i]; S_j = sum X_i^j, Sigma = prod (1 + X_i x).
   task automatic build_case(input int locs [8], input int n,
                             output logic [127:0] syn, output logic [63:0] sig);
      logic [7:0] x;
      logic [7:0] p [0:8];
      syn = '0;
      for (int k = 0; k <= 8; k++) p[k] = 8'h00;
      p[0] = 8'h01;
      for (int i = 0; i < n; i++) begin
         x = ref_pow(8'h02, locs[i]);
         for (int j = 1; j <= 16; j++) syn[8*(j-1) +: 8] = syn[8*(j-1) +: 8] ^ ref_pow(x, j);
         for (int k = 8; k >= 1; k--) p[k] = p[k] ^ ref_mul(p[k-1], x);
      end
      for (int k = 1; k <= 8; k++) sig[8*(k-1) +: 8] = p[k];
   endtask

   // ---------------- driver ----------------
   // Start is accepted at edge 0. pulse_a/pulse_b put extra Start pulses on
   // those edges. rst_at pulls Reset low from that edge for the rest of the
   // window. exp_dones is the number of Done pulses expected in the window.
   task automatic run_block(input string tag, input logic [127:0] syn,
                            input logic [69:0] exp_res, input int exp_lat,
                            input int pulse_a, input int pulse_b, input int rst_at,
                            input int exp_dones);
      int          done_cnt;
      int          lat;
      logic [63:0] got_sig;
      logic [4:0]  got_num;
      logic        got_fail;
      logic [69:0] e;
      done_cnt = 0;
      lat      = -1;
      got_sig  = '0;
      got_num  = '0;
      got_fail = 1'b0;
      if (rst_at == 0) exp_q.push_back(exp_res);
      Syndromes = syn;
      Start     = 1'b1;
      @(posedge Clk);
      #1;
      Start     = 1'b0;
      Syndromes = {$urandom, $urandom, $urandom, $urandom};
      check({tag, "_busy"}, 64'(Busy), 64'd1);
      for (int k = 1; k <= 55; k++) begin
         if (k == pulse_a || k == pulse_b) Start = 1'b1;
         if (k == rst_at) Reset = 1'b0;
         @(posedge Clk);
         #1;
         Start = 1'b0;
         if (Done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               lat      = k;
               got_sig  = {Sigma8, Sigma7, Sigma6, Sigma5, Sigma4, Sigma3, Sigma2, Sigma1};
               got_num  = Num_Errors;
               got_fail = Fail;
            end
         end
      end
      check({tag, "_dones"}, 64'(done_cnt), 64'(exp_dones));
      if (rst_at == 0) begin
         e = exp_q.pop_front();
         check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
         check({tag, "_sigma"}, got_sig, e[69:6]);
         check({tag, "_num"}, 64'(got_num), 64'(e[5:1]));
         check({tag, "_fail"}, 64'(got_fail), 64'(e[0]));
         if (exp_dones == 1) begin
            check({tag, "_idle_busy"}, 64'(Busy), 64'd0);
            check({tag, "_held_sigma"},
                  {Sigma8, Sigma7, Sigma6, Sigma5, Sigma4, Sigma3, Sigma2, Sigma1}, e[69:6]);
         end
      end else begin
         check({tag, "_rst_sigma"},
               {Sigma8, Sigma7, Sigma6, Sigma5, Sigma4, Sigma3, Sigma2, Sigma1}, 64'd0);
         check({tag, "_rst_num"}, 64'(Num_Errors), 64'd0);
         check({tag, "_rst_fail"}, 64'(Fail), 64'd0);
         check({tag, "_rst_busy"}, 64'(Busy), 64'd0);
         Reset = 1'b1;
         @(posedge Clk);
         #1;
         check({tag, "_rst_state"}, 64'(State_Dbg), 64'd0);
      end
   endtask

   // ---------------- stimulus ----------------
   logic [127:0] syn_single;
   logic [127:0] syn_8;
   logic [127:0] syn_2;
   logic [63:0]  sig_8;
   logic [63:0]  sig_2;
   int           locs8 [8];
   int           locs2 [8];

   initial begin
      // S_j = alpha^j for a single error at X = alpha
      syn_single = 128'h4C26_1387_CDE8_743A_1D80_4020_1008_0402;
      locs8 = '{3, 17, 40, 77, 101, 150, 188, 203};
      locs2 = '{5, 120, 0, 0, 0, 0, 0, 0};
      build_case(locs8, 8, syn_8, sig_8);
      build_case(locs2, 2, syn_2, sig_2);

      // Reset held low with Start high: everything stays cleared.
      Reset     = 1'b0;
      Start     = 1'b1;
      Syndromes = syn_single;
      repeat (2) @(posedge Clk);
      #1;
      check("reset_busy", 64'(Busy), 64'd0);
      check("reset_done", 64'(Done), 64'd0);
      check("reset_sigma",
            {Sigma8, Sigma7, Sigma6, Sigma5, Sigma4, Sigma3, Sigma2, Sigma1}, 64'd0);
      check("reset_num", 64'(Num_Errors), 64'd0);
      check("reset_fail", 64'(Fail), 64'd0);
      check("reset_state", 64'(State_Dbg), 64'd0);
      Reset = 1'b1;
      Start = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check("post_reset_idle", 64'(Busy), 64'd0);

      // Single error at alpha: Sigma1 = 02, L = 1.
      run_block("single", syn_single, {56'd0, 8'h02, 5'd1, 1'b0}, 25, 0, 0, 0, 1);
      // All-zero syndromes.
      run_block("zero", 128'd0, {64'd0, 5'd0, 1'b0}, ZERO_LAT, 0, 0, 0, 1);
      // Eight errors: full-capacity locator.
      run_block("eight", syn_8, {sig_8, 5'd8, 1'b0}, 25, 0, 0, 0, 1);
      // Two errors.
      run_block("two", syn_2, {sig_2, 5'd2, 1'b0}, 25, 0, 0, 0, 1);
      // S1 = 1 only: Lambda collapses to 1 with L = 1, so the block fails.
      run_block("degen", 128'h01, {64'd0, 5'd1, 1'b1}, 25, 0, 0, 0, 1);
      // Start during CALC is ignored.
      run_block("busy_start", syn_single, {56'd0, 8'h02, 5'd1, 1'b0}, 25, 5, 12, 0, 1);
      // Start sampled in DONE is ignored.
      run_block("done_start", syn_2, {sig_2, 5'd2, 1'b0}, 25, 25, 0, 0, 1);
      // Start during the Done cycle is accepted: a second block completes.
      run_block("b2b", syn_single, {56'd0, 8'h02, 5'd1, 1'b0}, 25, 26, 0, 0, 2);
      // Reset mid-run aborts with no Done and cleared outputs.
      run_block("abort", syn_8, 70'd0, 0, 5, 12, 10, 0);
      // Recovery after the abort.
      run_block("recover", syn_8, {sig_8, 5'd8, 1'b0}, 25, 0, 0, 0, 1);

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
